// File: rtl/la_spregfile_arb.sv
// la_spregfile_arb: shares one single-port register file between two
// valid/ready clients (A and B). Round-robin arbitration with optional
// bounded burst locking; 1-cycle read data is routed back to the reader.
module la_spregfile_arb #(
    parameter int DW       = 32,
    parameter int AW       = 10,
    parameter int MAXBURST = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    // port A
    input  logic          a_valid_i,
    output logic          a_ready_o,
    input  logic          a_we_i,
    input  logic          a_lock_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wmask_i,
    input  logic [DW-1:0] a_din_i,
    output logic          a_rvalid_o,
    output logic [DW-1:0] a_rdata_o,
    // port B
    input  logic          b_valid_i,
    output logic          b_ready_o,
    input  logic          b_we_i,
    input  logic          b_lock_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wmask_i,
    input  logic [DW-1:0] b_din_i,
    output logic          b_rvalid_o,
    output logic [DW-1:0] b_rdata_o,
    // memory port
    output logic          mem_ce_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wmask_o,
    output logic [DW-1:0] mem_din_o,
    input  logic [DW-1:0] mem_dout_i
);

    typedef enum logic {PRIO_A, PRIO_B} prio_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} own_e;

    localparam logic [7:0] MAXB = 8'(MAXBURST);

    prio_e      prio_q, prio_d;
    own_e       holder_q, holder_d;  // port currently holding a lock
    own_e       last_q, last_d;      // port granted in the previous cycle
    logic [7:0] burst_q, burst_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    logic       gnt_a, gnt_b;

    // Grant selection: lock holder first (bounded by MAXBURST), then the
    // sole requester, then the round-robin pointer. Nothing is granted in reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset_i) begin
            if (holder_q == OWN_A && a_valid_i) begin
                if (burst_q == MAXB && b_valid_i) gnt_b = 1'b1;
                else                              gnt_a = 1'b1;
            end else if (holder_q == OWN_B && b_valid_i) begin
                if (burst_q == MAXB && a_valid_i) gnt_a = 1'b1;
                else                              gnt_b = 1'b1;
            end else if (a_valid_i && !b_valid_i) begin
                gnt_a = 1'b1;
            end else if (b_valid_i && !a_valid_i) begin
                gnt_b = 1'b1;
            end else if (a_valid_i && b_valid_i) begin
                if (prio_q == PRIO_A) gnt_a = 1'b1;
                else                  gnt_b = 1'b1;
            end
        end
    end

    // Next-state: pointer flips away from the winner, lock follows the
    // winner's lock bit, burst counts consecutive grants to one port.
    always_comb begin
        prio_d   = prio_q;
        holder_d = OWN_NONE;
        last_d   = OWN_NONE;
        burst_d  = burst_q;
        if (gnt_a)      prio_d = PRIO_B;
        else if (gnt_b) prio_d = PRIO_A;
        if (gnt_a && a_lock_i)      holder_d = OWN_A;
        else if (gnt_b && b_lock_i) holder_d = OWN_B;
        if (gnt_a)      last_d = OWN_A;
        else if (gnt_b) last_d = OWN_B;
        if ((gnt_a && last_q == OWN_A) || (gnt_b && last_q == OWN_B)) begin
            if (burst_q != 8'hFF) burst_d = burst_q + 8'd1;
        end else if (gnt_a || gnt_b) begin
            burst_d = 8'd1;
        end
        pend_a_d = gnt_a && !a_we_i;
        pend_b_d = gnt_b && !b_we_i;
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q   <= PRIO_A;
            holder_q <= OWN_NONE;
            last_q   <= OWN_NONE;
            burst_q  <= 8'd0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            holder_q <= holder_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
        end
    end

    // Memory drive muxed from the winner; zeros when idle.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wmask_o = '0;
        mem_din_o   = '0;
        if (gnt_a) begin
            mem_we_o    = a_we_i;
            mem_addr_o  = a_addr_i;
            mem_wmask_o = a_wmask_i;
            mem_din_o   = a_din_i;
        end else if (gnt_b) begin
            mem_we_o    = b_we_i;
            mem_addr_o  = b_addr_i;
            mem_wmask_o = b_wmask_i;
            mem_din_o   = b_din_i;
        end
    end

    assign a_ready_o = gnt_a;
    assign b_ready_o = gnt_b;
    assign mem_ce_o  = gnt_a | gnt_b;

    // A read issued just before reset must not surface during reset.
    assign a_rvalid_o = pend_a_q && !reset_i;
    assign b_rvalid_o = pend_b_q && !reset_i;
    assign a_rdata_o  = a_rvalid_o ? mem_dout_i : '0;
    assign b_rdata_o  = b_rvalid_o ? mem_dout_i : '0;

endmodule

// File: tb/tb_la_spregfile_arb.sv
// tb_la_spregfile_arb: directed vector table plus a hand-written
// write-then-read sequence, against a behavioural single-port memory.
module tb_la_spregfile_arb;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam logic [31:0] F = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, a_ready, a_we, a_lock, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wmask, a_din, a_rdata;
    logic          b_valid, b_ready, b_we, b_lock, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wmask, b_din, b_rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wmask, mem_din;
    logic [DW-1:0] mem_dout = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    la_spregfile_arb #(.DW(DW), .AW(AW), .MAXBURST(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_we_i(a_we), .a_lock_i(a_lock),
        .a_addr_i(a_addr), .a_wmask_i(a_wmask), .a_din_i(a_din),
        .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we), .b_lock_i(b_lock),
        .b_addr_i(b_addr), .b_wmask_i(b_wmask), .b_din_i(b_din),
        .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wmask_o(mem_wmask), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
    );

    // Behavioural single-port register file, 1-cycle read latency.
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_ce && mem_we)
            mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
        else if (mem_ce)
            mem_dout <= mem[mem_addr];
    end

    typedef struct {
        logic          rst;
        logic          av, awe, alk;
        logic [AW-1:0] aaddr;
        logic [DW-1:0] adin, amsk;
        logic          bv, bwe, blk;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bdin, bmsk;
        logic          ear, ebr, ece, emwe;
        logic [AW-1:0] emaddr;
        logic          earv;
        logic [DW-1:0] eardata;
        logic          ebrv;
        logic [DW-1:0] ebrdata;
    } vec_t;

    function automatic vec_t row(
        logic rst,
        logic av, logic awe, logic alk, logic [AW-1:0] aaddr, logic [DW-1:0] adin, logic [DW-1:0] amsk,
        logic bv, logic bwe, logic blk, logic [AW-1:0] baddr, logic [DW-1:0] bdin, logic [DW-1:0] bmsk,
        logic ear, logic ebr, logic ece, logic emwe, logic [AW-1:0] emaddr,
        logic earv, logic [DW-1:0] eardata, logic ebrv, logic [DW-1:0] ebrdata);
        vec_t v;
        v.rst = rst;
        v.av = av; v.awe = awe; v.alk = alk; v.aaddr = aaddr; v.adin = adin; v.amsk = amsk;
        v.bv = bv; v.bwe = bwe; v.blk = blk; v.baddr = baddr; v.bdin = bdin; v.bmsk = bmsk;
        v.ear = ear; v.ebr = ebr; v.ece = ece; v.emwe = emwe; v.emaddr = emaddr;
        v.earv = earv; v.eardata = eardata; v.ebrv = ebrv; v.ebrdata = ebrdata;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive_idle();
        a_valid = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wmask = '0; a_din = '0;
        b_valid = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wmask = '0; b_din = '0;
    endtask

    vec_t tbl [30];

    initial begin
        // reset state; contention; burst lock; masked write; reset mid-read; lock drop
        tbl[0]  = row(1, 1,0,0,10'h3,0,F,                 1,0,0,10'h4,0,F,          0,0,0,0,10'h0,  0,0,            0,0);
        tbl[1]  = row(0, 1,1,0,10'h3,32'hDEADBEEF,F,      0,0,0,10'h0,0,0,          1,0,1,1,10'h3,  0,0,            0,0);
        tbl[2]  = row(0, 1,0,0,10'h3,0,F,                 0,0,0,10'h0,0,0,          1,0,1,0,10'h3,  0,0,            0,0);
        tbl[3]  = row(0, 0,0,0,10'h0,0,0,                 0,0,0,10'h0,0,0,          0,0,0,0,10'h0,  1,32'hDEADBEEF, 0,0);
        tbl[4]  = row(1, 1,1,0,10'h21,32'h11111111,F,     1,1,0,10'h42,32'h22222222,F, 0,0,0,0,10'h0, 0,0,          0,0);
        for (int i = 5; i <= 10; i++)
            tbl[i] = row(0, 1,1,0,10'h21,32'h11111111,F,  1,1,0,10'h42,32'h22222222,F,
                         (i%2)==1, (i%2)==0, 1,1, ((i%2)==1) ? 10'h21 : 10'h42, 0,0, 0,0);
        tbl[11] = row(0, 0,0,0,10'h0,0,0,                 0,0,0,10'h0,0,0,          0,0,0,0,10'h0,  0,0,            0,0);
        tbl[12] = row(0, 1,0,1,10'h21,0,F,                1,0,0,10'h42,0,F,         1,0,1,0,10'h21, 0,0,            0,0);
        for (int i = 13; i <= 15; i++)
            tbl[i] = row(0, 1,0,1,10'h21,0,F,             1,0,0,10'h42,0,F,         1,0,1,0,10'h21, 1,32'h11111111, 0,0);
        tbl[16] = row(0, 1,0,1,10'h21,0,F,                1,0,0,10'h42,0,F,         0,1,1,0,10'h42, 1,32'h11111111, 0,0);
        tbl[17] = row(0, 1,0,0,10'h21,0,F,                1,0,0,10'h42,0,F,         1,0,1,0,10'h21, 0,0,            1,32'h22222222);
        tbl[18] = row(0, 0,0,0,10'h0,0,0,                 1,1,0,10'h10,F,F,         0,1,1,1,10'h10, 1,32'h11111111, 0,0);
        tbl[19] = row(0, 0,0,0,10'h0,0,0,                 1,1,0,10'h10,0,32'h0000FFFF, 0,1,1,1,10'h10, 0,0,         0,0);
        tbl[20] = row(0, 0,0,0,10'h0,0,0,                 1,0,0,10'h10,0,0,         0,1,1,0,10'h10, 0,0,            0,0);
        tbl[21] = row(0, 0,0,0,10'h0,0,0,                 0,0,0,10'h0,0,0,          0,0,0,0,10'h0,  0,0,            1,32'hFFFF0000);
        tbl[22] = row(0, 1,0,0,10'h21,0,F,                0,0,0,10'h0,0,0,          1,0,1,0,10'h21, 0,0,            0,0);
        tbl[23] = row(1, 0,0,0,10'h0,0,0,                 0,0,0,10'h0,0,0,          0,0,0,0,10'h0,  0,0,            0,0);
        tbl[24] = row(0, 1,0,0,10'h21,0,F,                1,0,0,10'h42,0,F,         1,0,1,0,10'h21, 0,0,            0,0);
        tbl[25] = row(0, 0,0,0,10'h0,0,0,                 0,0,0,10'h0,0,0,          0,0,0,0,10'h0,  1,32'h11111111, 0,0);
        tbl[26] = row(0, 1,1,1,10'h30,32'h33333333,F,     0,0,0,10'h0,0,0,          1,0,1,1,10'h30, 0,0,            0,0);
        tbl[27] = row(0, 1,1,1,10'h30,32'h33333333,F,     1,1,0,10'h31,32'h44444444,F, 1,0,1,1,10'h30, 0,0,         0,0);
        tbl[28] = row(0, 0,0,0,10'h0,0,0,                 1,1,0,10'h31,32'h44444444,F, 0,1,1,1,10'h31, 0,0,         0,0);
        tbl[29] = row(0, 1,1,0,10'h30,32'h55555555,F,     1,1,0,10'h31,32'h66666666,F, 1,0,1,1,10'h30, 0,0,         0,0);

        reset = 1;
        drive_idle();
        repeat (2) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            #1;
            reset = tbl[i].rst;
            a_valid = tbl[i].av; a_we = tbl[i].awe; a_lock = tbl[i].alk;
            a_addr = tbl[i].aaddr; a_din = tbl[i].adin; a_wmask = tbl[i].amsk;
            b_valid = tbl[i].bv; b_we = tbl[i].bwe; b_lock = tbl[i].blk;
            b_addr = tbl[i].baddr; b_din = tbl[i].bdin; b_wmask = tbl[i].bmsk;
            @(negedge clk);
            chk("a_ready",  i, 32'(a_ready),  32'(tbl[i].ear));
            chk("b_ready",  i, 32'(b_ready),  32'(tbl[i].ebr));
            chk("mem_ce",   i, 32'(mem_ce),   32'(tbl[i].ece));
            chk("mem_we",   i, 32'(mem_we),   32'(tbl[i].emwe));
            chk("mem_addr", i, 32'(mem_addr), 32'(tbl[i].emaddr));
            chk("a_rvalid", i, 32'(a_rvalid), 32'(tbl[i].earv));
            chk("a_rdata",  i, a_rdata,       tbl[i].eardata);
            chk("b_rvalid", i, 32'(b_rvalid), 32'(tbl[i].ebrv));
            chk("b_rdata",  i, b_rdata,       tbl[i].ebrdata);
            @(posedge clk);
        end

        // Write in N, read same address in N+1, new data in N+2.
        #1;
        drive_idle();
        a_valid = 1; a_we = 1; a_addr = 10'h50; a_din = 32'hCAFEF00D; a_wmask = F;
        @(negedge clk);
        chk("wr_ready", 100, 32'(a_ready),  32'd1);
        chk("wr_din",   100, mem_din,       32'hCAFEF00D);
        chk("wr_wmask", 100, mem_wmask,     F);
        @(posedge clk); #1;
        a_we = 0; a_din = '0;
        @(negedge clk);
        chk("rd_ready", 101, 32'(a_ready),  32'd1);
        chk("rd_we",    101, 32'(mem_we),   32'd0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("rd_rvalid", 102, 32'(a_rvalid), 32'd1);
        chk("rd_rdata",  102, a_rdata,       32'hCAFEF00D);
        chk("rd_brvalid",102, 32'(b_rvalid), 32'd0);
        chk("idle_ce",   102, 32'(mem_ce),   32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
